// File: rtl/step_pkg.sv
// step_pkg: step pulse FSM state encoding and default tick counts
package step_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] REPEAT  = 2'd2;
  localparam int DEF_DEBOUNCE_TICKS = 500000;
  localparam int DEF_HOLD_TICKS     = 25000000;
  localparam int DEF_REPEAT_TICKS   = 10000000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus stable-count debouncer with level-change strobes
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic rise,
  output logic fall
);
  localparam int W = $clog2(DEBOUNCE_TICKS) + 1;
  logic sync1, sync2, accept;
  logic [W-1:0] cnt;
  assign accept = (sync2 != btn_level) && (cnt == W'(DEBOUNCE_TICKS - 1));
  assign rise = accept & sync2;
  assign fall = accept & ~sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      btn_level <= 1'b0;
      cnt <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      btn_level <= accept ? sync2 : btn_level;
      cnt <= (sync2 == btn_level || accept) ? '0 : (&cnt ? cnt : cnt + 1'b1);
    end
  end
endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: debounced pushbutton to one-cycle step strobe for the memory-dump address counter
// Define STEP_AUTOREPEAT_EN to add hold-to-repeat pulsing.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic step_pulse
);
  logic rise, fall;
  logic [1:0] state;
  if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > (1 << 20) || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("step_pulse_gen: tick parameters out of range");
  end
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_debounce (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .rise(rise),
    .fall(fall)
  );
`ifdef STEP_AUTOREPEAT_EN
  localparam int TW = $clog2(HOLD_TICKS > REPEAT_TICKS ? HOLD_TICKS : REPEAT_TICKS) + 1;
  logic [TW-1:0] tcnt;
  logic fire;
  assign fire = (state == PRESSED && tcnt == TW'(HOLD_TICKS - 1)) ||
                (state == REPEAT && tcnt == TW'(REPEAT_TICKS - 1));
  // A release on the same edge as a scheduled repeat wins: no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tcnt <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= rise | (fire & ~fall);
      state <= fall ? IDLE : rise ? PRESSED : fire ? REPEAT : state;
      tcnt <= (state == IDLE || fire) ? '0 : (&tcnt ? tcnt : tcnt + 1'b1);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= rise;
      state <= fall ? IDLE : rise ? PRESSED : state;
    end
  end
`endif
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed stimulus with a pulse-edge scoreboard for step_pulse_gen
module tb_step_pulse_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, step_pulse;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_q[$];

  step_pulse_gen #(.DEBOUNCE_TICKS(4), .HOLD_TICKS(20), .REPEAT_TICKS(8)) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step_pulse !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pulse_unexpected at edge %0d: got %b required no pulse", cyc, step_pulse);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc || step_pulse !== 1'b1) begin
          failures++;
          $display("FAIL pulse_edge: got pulse %b at edge %0d required 1 at edge %0d", step_pulse, cyc, e);
        end
      end
    end
  end

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %b required %b", name, cyc, act, exp);
    end
  endtask

  initial begin
    at(1);
    chk("reset_level", btn_level, 1'b0);
    chk("reset_pulse", step_pulse, 1'b0);
    at(3);
    reset = 1'b0;
    exp_q.push_back(15);
`ifdef STEP_AUTOREPEAT_EN
    exp_q.push_back(35);
    exp_q.push_back(43);
    exp_q.push_back(51);
    exp_q.push_back(59);
    exp_q.push_back(67);
`endif
    at(9);
    btn_in = 1'b1;
    at(14);
    chk("press_level_early", btn_level, 1'b0);
    at(15);
    chk("press_level", btn_level, 1'b1);
    chk("press_pulse", step_pulse, 1'b1);
    at(16);
    chk("press_pulse_one_cycle", step_pulse, 1'b0);
    at(69);
    btn_in = 1'b0;
    at(74);
    chk("release_level_early", btn_level, 1'b1);
    at(75);
    chk("release_level", btn_level, 1'b0);
    at(89);
    btn_in = 1'b1;
    at(92);
    btn_in = 1'b0;
    at(100);
    chk("glitch_level", btn_level, 1'b0);
    at(109);
    btn_in = 1'b1;
    at(110);
    btn_in = 1'b0;
    at(111);
    btn_in = 1'b1;
    at(112);
    btn_in = 1'b0;
    at(113);
    btn_in = 1'b1;
    exp_q.push_back(119);
    at(118);
    chk("bounce_level_early", btn_level, 1'b0);
    at(119);
    chk("bounce_level", btn_level, 1'b1);
    at(129);
    btn_in = 1'b0;
    at(134);
    chk("bounce_release_early", btn_level, 1'b1);
    at(135);
    chk("bounce_release", btn_level, 1'b0);
    at(149);
    btn_in = 1'b1;
    at(151);
    reset = 1'b1;
    at(152);
    chk("midreset_level", btn_level, 1'b0);
    chk("midreset_pulse", step_pulse, 1'b0);
    at(153);
    reset = 1'b0;
    exp_q.push_back(159);
    at(158);
    chk("postreset_level_early", btn_level, 1'b0);
    at(159);
    chk("postreset_level", btn_level, 1'b1);
    at(169);
    btn_in = 1'b0;
    at(175);
    chk("postreset_release", btn_level, 1'b0);
    at(200);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pulses_missing: got %0d outstanding required 0, next expected edge %0d", exp_q.size(), exp_q[0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
